// File: rtl/mat_tile_pingpong_pkg.sv
// mha_tile_pkg: shared sizes and matrix/tile array types for fetch, tiling and compute
// Shared by the fetch stage, mat_tile_pingpong and the MHA compute array.
package mha_tile_pkg;
    localparam int DATA_W    = 8;
    localparam int ROWS      = 16;
    localparam int COLS      = 128;
    localparam int TILE_W    = 16;
    localparam int NUM_TILES = COLS / TILE_W;
    localparam int IDX_W     = $clog2(NUM_TILES);
    localparam int TAG_W     = 6;
    typedef logic [DATA_W-1:0] elem_t;
    typedef elem_t [COLS-1:0] mat_row_t;
    typedef mat_row_t [ROWS-1:0] mat_t;
    typedef elem_t [TILE_W-1:0] tile_row_t;
    typedef tile_row_t [ROWS-1:0] tile_t;
    typedef enum logic {R_IDLE, R_STREAM} rd_state_t;
endpackage

// File: rtl/mat_tile_pingpong_mat_bank.sv
// mat_bank: one ROWSxCOLS matrix register bank with tag and column-tile read mux
// Ports: I_CLK/I_RST clock and async active-high reset; we loads mat_in and tag_in;
// idx selects the TILE_W-column slice presented on tile; tag is the stored tag.
module mat_bank
    import mha_tile_pkg::*;
(
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic             we,
    input  mat_t             mat_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic [IDX_W-1:0] idx,
    output tile_t            tile,
    output logic [TAG_W-1:0] tag
);
    mat_t mem;
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            mem <= '0;
            tag <= '0;
        end else if (we) begin
            mem <= mat_in;
            tag <= tag_in;
        end
    end
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [COLS*DATA_W-1:0] row;
        assign row     = mem[r];
        assign tile[r] = row[int'(idx)*TILE_W*DATA_W +: TILE_W*DATA_W];
    end
endmodule

// File: rtl/mat_tile_pingpong.sv
// mat_tile_pingpong: ping-pong matrix capture from the fetch stage, streamed out as column tiles
// Ports: I_CLK/I_RST clock and async active-high reset; I_MAT_VLD/I_MAT/I_SEL level-valid
// matrix and tag from fetch; O_IN_RDY a bank is free; O_OVF dropped-capture pulse;
// O_TILE_VLD/I_TILE_RDY tile handshake; O_TILE/O_TILE_IDX/O_TILE_LAST/O_TAG current tile.
module mat_tile_pingpong
    import mha_tile_pkg::*;
(
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic             I_MAT_VLD,
    input  mat_t             I_MAT,
    input  logic [TAG_W-1:0] I_SEL,
    output logic             O_IN_RDY,
    output logic             O_OVF,
    output logic             O_TILE_VLD,
    input  logic             I_TILE_RDY,
    output tile_t            O_TILE,
    output logic [IDX_W-1:0] O_TILE_IDX,
    output logic             O_TILE_LAST,
    output logic [TAG_W-1:0] O_TAG
);
    logic [1:0]       full, full_nx;
    logic             wr_bank, rd_bank, vld_d;
    logic [IDX_W-1:0] tile_idx;
    rd_state_t        rd_state;
    logic             cap, fire, rel, bank_free, wr_en;
    tile_t            tile_b [2];
    logic [TAG_W-1:0] tag_b [2];
    assign cap       = I_MAT_VLD && !vld_d;
    assign fire      = O_TILE_VLD && I_TILE_RDY;
    assign rel       = fire && tile_idx == IDX_W'(NUM_TILES-1);
    // a bank draining its last tile this cycle can take the new matrix on the same edge
    assign bank_free = !full[wr_bank] || (rel && rd_bank == wr_bank);
    assign wr_en     = cap && bank_free;
    for (genvar b = 0; b < 2; b++) begin : g_bank
        mat_bank u_bank (
            .I_CLK  (I_CLK),
            .I_RST  (I_RST),
            .we     (wr_en && wr_bank == 1'(b)),
            .mat_in (I_MAT),
            .tag_in (I_SEL),
            .idx    (tile_idx),
            .tile   (tile_b[b]),
            .tag    (tag_b[b])
        );
    end
    // capture is applied after release so a same-bank overlap keeps the bank full
    always_comb begin
        full_nx = full;
        if (rel) full_nx[rd_bank] = 1'b0;
        if (wr_en) full_nx[wr_bank] = 1'b1;
    end
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            tile_idx <= '0;
            vld_d    <= 1'b1;
            O_OVF    <= 1'b0;
            rd_state <= R_IDLE;
        end else begin
            full     <= full_nx;
            wr_bank  <= wr_bank ^ wr_en;
            rd_bank  <= rd_bank ^ rel;
            tile_idx <= rel ? '0 : tile_idx + IDX_W'(fire);
            vld_d    <= I_MAT_VLD;
            O_OVF    <= cap && !bank_free;
            rd_state <= full_nx[rd_bank ^ rel] ? R_STREAM : R_IDLE;
        end
    end
    assign O_TILE_VLD  = rd_state == R_STREAM;
    assign O_IN_RDY    = !full[wr_bank];
    assign O_TILE      = tile_b[rd_bank];
    assign O_TAG       = tag_b[rd_bank];
    assign O_TILE_IDX  = tile_idx;
    assign O_TILE_LAST = O_TILE_VLD && tile_idx == IDX_W'(NUM_TILES-1);
endmodule

// File: tb/tb_mat_tile_pingpong.sv
// tb_mat_tile_pingpong: table-driven and directed self-checking bench for mat_tile_pingpong
module tb_mat_tile_pingpong;
    import mha_tile_pkg::*;
    logic             I_CLK, I_RST, I_MAT_VLD, I_TILE_RDY;
    mat_t             I_MAT;
    logic [TAG_W-1:0] I_SEL, O_TAG;
    logic             O_IN_RDY, O_OVF, O_TILE_VLD, O_TILE_LAST;
    tile_t            O_TILE;
    logic [IDX_W-1:0] O_TILE_IDX;
    int ncmp = 0;
    int nerr = 0;

    mat_tile_pingpong dut (
        .I_CLK       (I_CLK),
        .I_RST       (I_RST),
        .I_MAT_VLD   (I_MAT_VLD),
        .I_MAT       (I_MAT),
        .I_SEL       (I_SEL),
        .O_IN_RDY    (O_IN_RDY),
        .O_OVF       (O_OVF),
        .O_TILE_VLD  (O_TILE_VLD),
        .I_TILE_RDY  (I_TILE_RDY),
        .O_TILE      (O_TILE),
        .O_TILE_IDX  (O_TILE_IDX),
        .O_TILE_LAST (O_TILE_LAST),
        .O_TAG       (O_TAG)
    );

    initial begin
        I_CLK = 1'b0;
        forever #5 I_CLK = ~I_CLK;
    end

    typedef struct {
        bit vld; int seed; int sel; bit rdy;
        bit e_vld; int e_idx; int e_tag; int e_seed; bit e_ovf; bit e_inrdy;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit vld, int seed, int sel, bit rdy,
                                bit e_vld, int e_idx, int e_tag, int e_seed, bit e_ovf, bit e_inrdy);
        vec_t v;
        v = '{vld, seed, sel, rdy, e_vld, e_idx, e_tag, e_seed, e_ovf, e_inrdy};
        tbl.push_back(v);
    endfunction

    // seed 0 is the plain r*128+c pattern; other seeds xor a distinct constant
    function automatic logic [7:0] elem(int seed, int r, int c);
        return 8'(r*128 + c) ^ 8'(seed*53);
    endfunction

    function automatic mat_t gen(int seed);
        mat_t m;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m[r][c] = elem(seed, r, c);
        return m;
    endfunction

    function automatic tile_t exp_tile(int seed, int k);
        tile_t t;
        for (int r = 0; r < ROWS; r++)
            for (int j = 0; j < TILE_W; j++)
                t[r][j] = elem(seed, r, k*TILE_W + j);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_tile(input string nm, input tile_t e);
        ncmp++;
        if (O_TILE !== e) begin
            int fr = 0;
            int fc = 0;
            nerr++;
            for (int r = ROWS-1; r >= 0; r--)
                for (int j = TILE_W-1; j >= 0; j--)
                    if (O_TILE[r][j] !== e[r][j]) begin fr = r; fc = j; end
            $display("FAIL %s: tile[%0d][%0d] got %0h expected %0h", nm, fr, fc, O_TILE[fr][fc], e[fr][fc]);
        end
    endtask

    task automatic step(input bit v, input int seed, input int sel, input bit rdy);
        I_MAT_VLD  = v;
        I_MAT      = gen(seed);
        I_SEL      = 6'(sel);
        I_TILE_RDY = rdy;
        @(posedge I_CLK);
        #1;
    endtask

    // consumes beats k0..k1-1; repeated checks during stalls prove the tile holds still
    task automatic drain(input int seed, input int tag, input bit stall, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            int n;
            bit r;
            n = 0;
            do begin
                chk($sformatf("drain s%0d k%0d vld", seed, k), O_TILE_VLD, 1);
                chk($sformatf("drain s%0d k%0d idx", seed, k), O_TILE_IDX, k);
                chk($sformatf("drain s%0d k%0d last", seed, k), O_TILE_LAST, k == NUM_TILES-1);
                chk($sformatf("drain s%0d k%0d tag", seed, k), O_TAG, tag);
                chk($sformatf("drain s%0d k%0d ovf", seed, k), O_OVF, 0);
                chk_tile($sformatf("drain s%0d k%0d tile", seed, k), exp_tile(seed, k));
                r = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (n == 4) r = 1'b1;
                I_TILE_RDY = r;
                @(posedge I_CLK);
                #1;
                n++;
            end while (!r);
        end
    endtask

    initial begin
        // single capture, seed 0 tag 5, full-rate drain
        add(1, 0, 5, 1, 1, 0, 5, 0, 0, 1);
        for (int k = 1; k < 8; k++) add(1, 0, 5, 1, 1, k, 5, 0, 0, 1);
        add(0, 0, 5, 1, 0, 0, 0, 0, 0, 1);
        // captures three cycles apart into bank 1 then bank 0, 16 contiguous beats
        add(1, 1, 1, 1, 1, 0, 1, 1, 0, 1);
        add(0, 1, 1, 1, 1, 1, 1, 1, 0, 1);
        add(0, 1, 1, 1, 1, 2, 1, 1, 0, 1);
        add(1, 2, 2, 1, 1, 3, 1, 1, 0, 0);
        for (int k = 4; k < 8; k++) add(1, 2, 2, 1, 1, k, 1, 1, 0, 0);
        add(1, 2, 2, 1, 1, 0, 2, 2, 0, 1);
        for (int k = 1; k < 8; k++) add(1, 2, 2, 1, 1, k, 2, 2, 0, 1);
        add(0, 2, 2, 1, 0, 0, 1, 2, 0, 1);

        // reset with valid held high: nothing captured after release
        I_RST = 1'b1; I_MAT_VLD = 1'b1; I_MAT = gen(9); I_SEL = 6'd9; I_TILE_RDY = 1'b0;
        repeat (3) @(posedge I_CLK);
        #1;
        I_RST = 1'b0;
        chk("rst in_rdy", O_IN_RDY, 1);
        chk("rst tile_vld", O_TILE_VLD, 0);
        chk("rst ovf", O_OVF, 0);
        chk("rst idx", O_TILE_IDX, 0);
        chk("rst last", O_TILE_LAST, 0);
        chk("rst tag", O_TAG, 0);
        chk_tile("rst tile", '0);
        for (int i = 0; i < 3; i++) begin
            step(1, 9, 9, 0);
            chk("held vld", O_TILE_VLD, 0);
            chk("held in_rdy", O_IN_RDY, 1);
            chk("held ovf", O_OVF, 0);
        end
        step(0, 9, 9, 0);

        foreach (tbl[i]) begin
            step(tbl[i].vld, tbl[i].seed, tbl[i].sel, tbl[i].rdy);
            chk($sformatf("v%0d vld", i), O_TILE_VLD, tbl[i].e_vld);
            chk($sformatf("v%0d idx", i), O_TILE_IDX, tbl[i].e_idx);
            chk($sformatf("v%0d last", i), O_TILE_LAST, tbl[i].e_vld && tbl[i].e_idx == 7);
            chk($sformatf("v%0d tag", i), O_TAG, tbl[i].e_tag);
            chk($sformatf("v%0d ovf", i), O_OVF, tbl[i].e_ovf);
            chk($sformatf("v%0d in_rdy", i), O_IN_RDY, tbl[i].e_inrdy);
            if (tbl[i].e_vld) chk_tile($sformatf("v%0d tile", i), exp_tile(tbl[i].e_seed, tbl[i].e_idx));
        end

        // fill both banks with RDY low, then a third edge overflows
        step(1, 3, 3, 0);
        chk("ovfseq vld", O_TILE_VLD, 1);
        chk("ovfseq in_rdy1", O_IN_RDY, 1);
        step(0, 3, 3, 0);
        step(1, 4, 4, 0);
        chk("ovfseq in_rdy0", O_IN_RDY, 0);
        chk("ovfseq ovf early", O_OVF, 0);
        step(0, 4, 4, 0);
        step(1, 5, 6, 0);
        chk("ovfseq ovf", O_OVF, 1);
        chk("ovfseq in_rdy", O_IN_RDY, 0);
        chk("ovfseq idx", O_TILE_IDX, 0);
        chk("ovfseq tag", O_TAG, 3);
        chk_tile("ovfseq tile", exp_tile(3, 0));
        step(1, 5, 6, 0);
        chk("ovfseq pulse end", O_OVF, 0);
        I_MAT_VLD = 1'b0;

        // release of bank 1 on the same edge as a capture into bank 1
        drain(3, 3, 0, 0, 7);
        chk("same last", O_TILE_LAST, 1);
        step(1, 6, 7, 1);
        chk("same ovf", O_OVF, 0);
        chk("same vld", O_TILE_VLD, 1);
        chk("same tag", O_TAG, 4);
        chk("same in_rdy", O_IN_RDY, 0);
        drain(4, 4, 0, 0, 8);
        chk("same in_rdy after", O_IN_RDY, 1);
        drain(6, 7, 1, 0, 8);
        chk("stall end vld", O_TILE_VLD, 0);

        // asynchronous reset mid-stream
        step(0, 6, 7, 0);
        step(1, 7, 9, 0);
        chk("mid vld", O_TILE_VLD, 1);
        chk("mid tag", O_TAG, 9);
        step(1, 7, 9, 1);
        chk("mid idx", O_TILE_IDX, 1);
        #2 I_RST = 1'b1;
        #1;
        chk("async vld", O_TILE_VLD, 0);
        chk("async idx", O_TILE_IDX, 0);
        chk("async tag", O_TAG, 0);
        chk("async in_rdy", O_IN_RDY, 1);
        chk_tile("async tile", '0);
        @(posedge I_CLK);
        #1;
        I_RST = 1'b0;
        step(1, 7, 9, 1);
        step(1, 7, 9, 1);
        chk("post rst vld", O_TILE_VLD, 0);
        chk("post rst ovf", O_OVF, 0);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end
endmodule
